qmax_scan: RTL

- Sequential max-Q search unit for the Q-learning datapath.
- Accepts the Q-values of all actions for the next state, one per handshake, in sign-magnitude fixed point (Q frac bits, N total, MSB = sign).
- Returns the maximum value and its action index.
- Output feeds the fixed-point adder stage that forms r + gamma*maxQ'.

---
 rtl/qmax_scan.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/qmax_scan.sv
// qmax_scan -- sequential max-Q search unit.
//
// Accepts the Q-values of all A actions for the next state, one per
// q_valid/q_ready handshake. Values are sign-magnitude fixed point with
// Q fractional bits and N total bits; bit N-1 is the sign. The block returns
// the maximum value (max_q) and its action index (max_idx). Both are
// registered and qualified by a one-cycle done pulse. They feed the
// fixed-point adder stage that forms r + gamma*maxQ'.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    begins a search (sampled in IDLE only)
//   abort    synchronous cancel back to IDLE; max_q/max_idx untouched
//   q_in     sign-magnitude Q-value of action number cnt
//   q_valid  q_in valid
//   q_ready  block accepts q_in this cycle (high in SCAN)
//   max_q    registered maximum, canonical sign-magnitude (no -0)
//   max_idx  action index of the maximum
//   done     one-cycle pulse; max_q/max_idx just updated
//   busy     high in SCAN and DONE
module qmax_scan #(
  parameter int Q  = 9,
  parameter int N  = 14,
  parameter int A  = 4,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  q_in,
  input  logic          q_valid,
  output logic          q_ready,
  output logic [N-1:0]  max_q,
  output logic [IW-1:0] max_idx,
  output logic          done,
  output logic          busy
);

  // Elaboration-time parameter sanity checks.
  if (A < 2 || A > 16) begin : g_bad_a
    $error("qmax_scan: A must be in 2..16");
  end
  if ((1 << IW) < A) begin : g_bad_iw
    $error("qmax_scan: IW too narrow for A");
  end
  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("qmax_scan: Q must fit inside the magnitude field");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] cnt;
  logic [N-1:0]  best;
  logic [IW-1:0] best_idx;

  logic          accept;
  logic          take;
  logic          last;
  logic          replace;
  logic [N-1:0]  best_nxt;
  logic [IW-1:0] best_idx_nxt;

  // Map negative zero onto +0 so every comparison sees one zero.
  function automatic logic [N-1:0] sm_canon(input logic [N-1:0] v);
    return (v[N-2:0] == '0) ? '0 : v;
  endfunction

  // Strict sign-magnitude "a > b".
  function automatic logic sm_gt(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] ca;
    logic [N-1:0] cb;
    ca = sm_canon(a);
    cb = sm_canon(b);
    if (ca[N-1] != cb[N-1]) begin
      return cb[N-1];                      // a positive, b negative
    end else if (!ca[N-1]) begin
      return ca[N-2:0] > cb[N-2:0];        // both positive: larger magnitude
    end else begin
      return ca[N-2:0] < cb[N-2:0];        // both negative: smaller magnitude
    end
  endfunction

  // ---------------------------------------------------------------------
  // Handshake and compare/select datapath
  // ---------------------------------------------------------------------
  // An accept that coincides with abort is discarded, so it is excluded
  // from take.
  assign accept = q_valid & q_ready;
  assign take   = accept & ~abort;
  assign last   = (cnt == IW'(A - 1));

  // The first value of a search loads unconditionally. Later values replace
  // only when strictly greater, so ties keep the earlier index.
  always_comb begin
    replace      = (cnt == '0) || sm_gt(q_in, best);
    best_nxt     = best;
    best_idx_nxt = best_idx;
    if (replace) begin
      best_nxt     = q_in;
      best_idx_nxt = cnt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (take && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: Moore outputs decoded from the state register
  // ---------------------------------------------------------------------
  always_comb begin
    q_ready = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
      end
      SCAN: begin
        q_ready = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counter, running best and result registers
  // ---------------------------------------------------------------------
  // The result registers load from the combinational select on the last
  // accept. They are therefore already valid in the DONE cycle, one cycle
  // after that accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      max_q    <= '0;
      max_idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            cnt <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            cnt <= '0;
          end else if (take) begin
            best     <= best_nxt;
            best_idx <= best_idx_nxt;
            if (last) begin
              cnt     <= '0;
              max_q   <= sm_canon(best_nxt);
              max_idx <= best_idx_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
